pid_drive: RTL and testbench

Downstream consumer of the proportional stage in the PID balance-control path. Registers a valid set of P, I and D terms, sums them into a saturated signed 12-bit PID value, and converts it to a direction bit plus an 11-bit glitch-free PWM drive for the motor bridge. The block supplies the only path from the control terms to the motor pins.

---
 rtl/pid_drive_pkg.sv | 56 +++++
 rtl/pid_drive_pwm11.sv | 51 +++++
 rtl/pid_drive.sv | 80 ++++++++
 tb/tb_pid_drive.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_drive_pkg.sv
// Shared constants, types and helpers for the PID drive path.
// Holds the sum/PWM widths, the saturation limits and the two arithmetic
// helpers (clamp to 12 bits, magnitude for the PWM duty).
package pid_pkg;

  // PWM counter/duty width; one PWM period is 2**PWM_W clocks
  localparam int PWM_W = 11;
  // Internal width used when summing the three sign-extended terms
  localparam int SUM_W = 16;

  // Term and result types
  typedef logic signed [13:0]      p_term_t;
  typedef logic signed [11:0]      i_term_t;
  typedef logic signed [12:0]      d_term_t;
  typedef logic signed [11:0]      pid_t;
  typedef logic        [PWM_W-1:0] duty_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  // Saturation limits of the PID value
  localparam pid_t PID_MAX = 12'sh7FF;
  localparam pid_t PID_MIN = 12'sh800;

  // Same limits expressed at sum width for the compare
  localparam sum_t SUM_MAX = 16'sd2047;
  localparam sum_t SUM_MIN = -16'sd2048;

  // Clamp a full-width sum into the signed 12-bit PID range
  function automatic pid_t sat_sum(input sum_t s);
    pid_t r;
    if (s > SUM_MAX) begin
      r = PID_MAX;
    end else if (s < SUM_MIN) begin
      r = PID_MIN;
    end else begin
      r = s[11:0];
    end
    return r;
  endfunction

  // Magnitude of a PID value as an 11-bit duty; the most negative value
  // has no 11-bit magnitude, so it is pinned to full scale
  function automatic duty_t abs_mag(input pid_t v);
    pid_t  neg;
    duty_t r;
    neg = -v;
    if (v == PID_MIN) begin
      r = '1;
    end else if (v[11]) begin
      r = neg[PWM_W-1:0];
    end else begin
      r = v[PWM_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pid_drive_pwm11.sv
// Free-running 11-bit PWM generator for the motor bridge.
// The duty and direction are only swapped in on the counter wrap, so a
// period is never cut short or stretched and the output stays glitch-free.
module pwm11
  import pid_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] duty_pend,
  input  logic             dir_pend,
  output logic             pwm,
  output logic             dir
);

  logic [PWM_W-1:0] cnt;
  logic [PWM_W-1:0] duty_act;
  logic             wrap;

  // The wrap cycle is the one where the counter holds its maximum value
  assign wrap = &cnt;

  // Period counter; rolls from all-ones back to zero on its own
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Take the pending duty/direction only at the period boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_act <= '0;
      dir      <= 1'b0;
    end else if (wrap) begin
      duty_act <= duty_pend;
      dir      <= dir_pend;
    end
  end

  // Registered compare so the bridge pin is driven straight from a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= 1'b0;
    end else begin
      pwm <= (cnt < duty_act);
    end
  end

endmodule

// File: rtl/pid_drive.sv
// PID drive stage: sums the P, I and D terms, saturates to a signed 12-bit
// PID value and turns it into a direction bit plus PWM duty for the bridge.
// Two register stages (sum, then saturate) feed a pending duty/direction
// register that the PWM generator samples at each period boundary.
module pid_drive
  import pid_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [13:0] P_term,
  input  logic [11:0] I_term,
  input  logic [12:0] D_term,
  output logic [11:0] PID_sat,
  output logic        sat_vld,
  output logic        dir,
  output logic        pwm
);

  sum_t  p_ext;
  sum_t  i_ext;
  sum_t  d_ext;
  sum_t  sum_d;
  sum_t  sum_q;
  logic  s1_vld;
  pid_t  sat_d;
  duty_t mag_pend;
  logic  dir_pend;

  // Sign-extend the three terms to the common sum width
  assign p_ext = {{(SUM_W-14){P_term[13]}}, P_term};
  assign i_ext = {{(SUM_W-12){I_term[11]}}, I_term};
  assign d_ext = {{(SUM_W-13){D_term[12]}}, D_term};

  // Raw sum of the incoming terms and saturated view of the stored sum
  always_comb begin
    sum_d = p_ext + i_ext + d_ext;
    sat_d = sat_sum(sum_q);
  end

  // Stage 1: capture the sum only when the terms are flagged valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= vld;
      if (vld) begin
        sum_q <= sum_d;
      end
    end
  end

  // Stage 2: publish the saturated value and refresh the pending drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PID_sat  <= '0;
      sat_vld  <= 1'b0;
      mag_pend <= '0;
      dir_pend <= 1'b0;
    end else begin
      sat_vld <= s1_vld;
      if (s1_vld) begin
        PID_sat  <= sat_d;
        mag_pend <= abs_mag(sat_d);
        dir_pend <= sat_d[11];
      end
    end
  end

  pwm11 u_pwm (
    .clk       (clk),
    .rst_n     (rst_n),
    .duty_pend (mag_pend),
    .dir_pend  (dir_pend),
    .pwm       (pwm),
    .dir       (dir)
  );

endmodule

// File: tb/tb_pid_drive.sv
// Self-checking bench for pid_drive: scoreboard on sat_vld plus a
// period-level model of the PWM duty and direction.
module tb_pid_drive;

  localparam int PERIOD = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic [13:0] P_term = '0;
  logic [11:0] I_term = '0;
  logic [12:0] D_term = '0;
  logic [11:0] PID_sat;
  logic        sat_vld;
  logic        dir;
  logic        pwm;

  typedef struct {
    int edge_n;
    int pid;
    int mag;
    bit neg;
  } exp_t;

  exp_t sbq[$];
  exp_t updq[$];

  int tests = 0;
  int fails = 0;
  int ecnt = 0;
  int hi_cnt = 0;
  int fin_duty = 0;
  int cur_duty = 0;
  int pend_mag = 0;
  bit cur_dir = 1'b0;
  bit pend_dir = 1'b0;

  pid_drive dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld     (vld),
    .P_term  (P_term),
    .I_term  (I_term),
    .D_term  (D_term),
    .PID_sat (PID_sat),
    .sat_vld (sat_vld),
    .dir     (dir),
    .pwm     (pwm)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: plain integer sum, clamp, magnitude
  function automatic void refModel(input int p, input int i, input int d,
                                   output int pid, output int mag, output bit neg);
    int s;
    s = p + i + d;
    if (s > 2047) pid = 2047;
    else if (s < -2048) pid = -2048;
    else pid = s;
    neg = (pid < 0);
    if (pid == -2048) mag = 2047;
    else if (pid < 0) mag = -pid;
    else mag = pid;
  endfunction

  // Called at a negedge; drives one vld cycle and records expectations
  task automatic applyStimulus(input int p, input int i, input int d);
    exp_t e;
    int   pid;
    int   mag;
    bit   neg;
    P_term = p[13:0];
    I_term = i[11:0];
    D_term = d[12:0];
    vld = 1'b1;
    refModel(p, i, d, pid, mag, neg);
    e.edge_n = ecnt + 2;
    e.pid = pid;
    e.mag = mag;
    e.neg = neg;
    sbq.push_back(e);
    updq.push_back(e);
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic waitToCnt(input int c);
    do @(negedge clk); while ((ecnt % PERIOD) != c);
  endtask

  task automatic runPeriods(input int n);
    repeat (n * PERIOD) @(negedge clk);
  endtask

  task automatic applyRandom();
    int p;
    int i;
    int d;
    if ($urandom_range(0, 1) == 1) begin
      p = int'($urandom_range(0, 16383)) - 8192;
      i = int'($urandom_range(0, 4095)) - 2048;
      d = int'($urandom_range(0, 8191)) - 4096;
    end else begin
      p = int'($urandom_range(0, 1600)) - 800;
      i = int'($urandom_range(0, 1200)) - 600;
      d = int'($urandom_range(0, 1000)) - 500;
    end
    applyStimulus(p, i, d);
  endtask

  // Period model: at each boundary the last value published strictly
  // before that boundary becomes the active duty/direction
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) begin
        ecnt++;
        if ((ecnt % PERIOD) == 0) begin
          fin_duty = cur_duty;
          cur_duty = pend_mag;
          cur_dir  = pend_dir;
        end
        while (updq.size() > 0 && updq[0].edge_n == ecnt) begin
          pend_mag = updq[0].mag;
          pend_dir = updq[0].neg;
          void'(updq.pop_front());
        end
      end
    end
  end

  // Monitor: scoreboard on sat_vld, PWM high-time per period, direction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sat_vld) begin
          if (sbq.size() == 0) begin
            checkOutput("sat_vld_unexpected", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            checkOutput("PID_sat", {20'd0, PID_sat}, e.pid & 32'hFFF);
            checkOutput("sat_latency", ecnt, e.edge_n);
          end
        end
        if (pwm) hi_cnt++;
        if (ecnt > 0 && (ecnt % PERIOD) == 0) begin
          checkOutput("pwm_high_cycles", hi_cnt, fin_duty);
          checkOutput("dir_at_wrap", {31'd0, dir}, {31'd0, cur_dir});
          hi_cnt = 0;
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_PID_sat", {20'd0, PID_sat}, 32'd0);
    checkOutput("reset_sat_vld", {31'd0, sat_vld}, 32'd0);
    checkOutput("reset_dir", {31'd0, dir}, 32'd0);
    checkOutput("reset_pwm", {31'd0, pwm}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Nominal 1533 + 256 = 1789
    repeat (10) @(negedge clk);
    applyStimulus(1533, 256, 0);
    runPeriods(3);

    // Positive saturation
    applyStimulus(1533, 2047, 4095);
    runPeriods(2);

    // Negative saturation: -1536 - 2048 clamps to -2048, duty 2047
    applyStimulus(-1536, -2048, 0);
    runPeriods(2);

    // Zero, then mid-period update to 500
    applyStimulus(0, 0, 0);
    runPeriods(2);
    waitToCnt(1000);
    applyStimulus(500, 0, 0);
    runPeriods(2);

    // Two updates in one period: only the later applies
    waitToCnt(100);
    applyStimulus(300, 0, 0);
    waitToCnt(900);
    applyStimulus(-400, 0, 0);
    runPeriods(2);

    // Publication lands on the wrap edge: applies one period later
    waitToCnt(2046);
    applyStimulus(1000, 0, 0);
    runPeriods(2);

    // Random spaced updates, then a back-to-back burst
    repeat (16) begin
      repeat ($urandom_range(0, 250)) @(negedge clk);
      applyRandom();
    end
    repeat (8) applyRandom();
    runPeriods(2);

    // Asynchronous reset in the middle of a -1789 period
    applyStimulus(-1533, -256, 0);
    runPeriods(1);
    waitToCnt(500);
    checkOutput("pwm_before_reset", {31'd0, pwm}, 32'd1);
    checkOutput("dir_before_reset", {31'd0, dir}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_pwm", {31'd0, pwm}, 32'd0);
    checkOutput("async_reset_dir", {31'd0, dir}, 32'd0);
    checkOutput("async_reset_PID_sat", {20'd0, PID_sat}, 32'd0);
    sbq.delete();
    updq.delete();
    ecnt = 0;
    hi_cnt = 0;
    fin_duty = 0;
    cur_duty = 0;
    pend_mag = 0;
    cur_dir = 1'b0;
    pend_dir = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    runPeriods(2);

    checkOutput("scoreboard_drained", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
